// File: rtl/dl_shift_arb_if.sv
// Bundle of requester and response signals for dl_shift_arb.
// master = requester/consumer side, slave = arbiter side.
interface dl_shift_arb_if #(
    parameter int NUM_BITS = 32,
    parameter int NUM_REQ  = 4
);
    localparam int NUM_SHIFT_BITS = $clog2(NUM_BITS);
    localparam int ID_BITS        = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                          req_valid;
    logic [NUM_REQ-1:0]                          req_ready;
    logic [NUM_REQ-1:0][1:0]                     req_op;
    logic [NUM_REQ-1:0][NUM_BITS-1:0]            req_data;
    logic [NUM_REQ-1:0][NUM_SHIFT_BITS-1:0]      req_shamt;
    logic                                        rsp_valid;
    logic                                        rsp_ready;
    logic [NUM_BITS-1:0]                         rsp_data;
    logic [ID_BITS-1:0]                          rsp_id;
    logic                                        rsp_err;

    modport master (
        output req_valid, req_op, req_data, req_shamt, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_data, req_shamt, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
    );
endinterface

// File: rtl/dl_shift_arb.sv
// Round-robin arbiter sharing one right-shifter among NUM_REQ requesters, with a registered response.
// Define DL_SHIFT_ARB_LSHIFT_EN to build SLL (op 10) via operand/result bit reversal.
module dl_shift_arb #(
    parameter int NUM_BITS = 32,
    parameter int NUM_REQ  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    dl_shift_arb_if.slave   bus
);
    localparam int NUM_SHIFT_BITS = $clog2(NUM_BITS);
    localparam int ID_BITS        = $clog2(NUM_REQ);

    localparam logic [1:0] OP_SRL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_SLL = 2'b10;

`ifdef DL_SHIFT_ARB_LSHIFT_EN
    function automatic logic [NUM_BITS-1:0] bit_rev(input logic [NUM_BITS-1:0] v);
        logic [NUM_BITS-1:0] r;
        for (int i = 0; i < NUM_BITS; i++) begin
            r[i] = v[NUM_BITS-1-i];
        end
        return r;
    endfunction
`endif

    logic [ID_BITS-1:0]         ptr_r;
    logic                       rsp_valid_r;
    logic [NUM_BITS-1:0]        rsp_data_r;
    logic [ID_BITS-1:0]         rsp_id_r;
    logic                       rsp_err_r;

    logic [NUM_REQ-1:0]         grant_s;
    logic [ID_BITS-1:0]         winner_s;
    logic                       found_s;
    logic                       can_accept_s;
    logic                       xfer_s;
    logic [ID_BITS-1:0]         ptr_next_s;

    logic [1:0]                 op_s;
    logic [NUM_BITS-1:0]        data_s;
    logic [NUM_SHIFT_BITS-1:0]  shamt_s;
    logic                       supported_s;
    logic                       fill_s;
    logic [NUM_BITS-1:0]        srl_in_s;
    logic [NUM_BITS-1:0]        shifted_s;
    logic [NUM_BITS-1:0]        result_s;
`ifdef DL_SHIFT_ARB_LSHIFT_EN
    logic                       rev_s;
`endif

    assign can_accept_s = ~rsp_valid_r | bus.rsp_ready;
    assign xfer_s       = found_s & can_accept_s;
    assign ptr_next_s   = (winner_s == ID_BITS'(NUM_REQ - 1)) ? {ID_BITS{1'b0}} : (winner_s + ID_BITS'(1));

    // Round-robin search for the first valid requester starting at the pointer.
    always_comb begin
        grant_s  = {NUM_REQ{1'b0}};
        winner_s = {ID_BITS{1'b0}};
        found_s  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found_s && bus.req_valid[(int'(ptr_r) + k) % NUM_REQ]) begin
                found_s  = 1'b1;
                winner_s = ID_BITS'((int'(ptr_r) + k) % NUM_REQ);
            end else begin
                winner_s = winner_s;
            end
        end
        grant_s[winner_s] = found_s;
    end

    // Keep req_ready low during reset even though the response stage looks empty.
    assign bus.req_ready = grant_s & {NUM_REQ{can_accept_s & rst_n}};

    // Decode the winner's op and run the shared right shifter.
    always_comb begin
        op_s        = bus.req_op[winner_s];
        data_s      = bus.req_data[winner_s];
        shamt_s     = bus.req_shamt[winner_s];
        supported_s = 1'b0;
        fill_s      = 1'b0;
`ifdef DL_SHIFT_ARB_LSHIFT_EN
        rev_s       = 1'b0;
`endif
        case (op_s)
            OP_SRL: supported_s = 1'b1;
            OP_SRA: begin
                supported_s = 1'b1;
                fill_s      = data_s[NUM_BITS-1];
            end
            OP_SLL: begin
`ifdef DL_SHIFT_ARB_LSHIFT_EN
                supported_s = 1'b1;
                rev_s       = 1'b1;
`else
                supported_s = 1'b0;
`endif
            end
            default: supported_s = 1'b0;
        endcase
`ifdef DL_SHIFT_ARB_LSHIFT_EN
        srl_in_s  = rev_s ? bit_rev(data_s) : data_s;
`else
        srl_in_s  = data_s;
`endif
        shifted_s = (srl_in_s >> shamt_s) |
                    (fill_s ? ~({NUM_BITS{1'b1}} >> shamt_s) : {NUM_BITS{1'b0}});
        if (!supported_s) begin
            result_s = data_s;
        end else begin
`ifdef DL_SHIFT_ARB_LSHIFT_EN
            result_s = rev_s ? bit_rev(shifted_s) : shifted_s;
`else
            result_s = shifted_s;
`endif
        end
    end

    // Response register and round-robin pointer; a new transfer overwrites a draining response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r       <= {ID_BITS{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {NUM_BITS{1'b0}};
            rsp_id_r    <= {ID_BITS{1'b0}};
            rsp_err_r   <= 1'b0;
        end else if (xfer_s) begin
            ptr_r       <= ptr_next_s;
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= result_s;
            rsp_id_r    <= winner_s;
            rsp_err_r   <= ~supported_s;
        end else if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end else begin
            rsp_valid_r <= rsp_valid_r;
        end
    end

    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_id    = rsp_id_r;
    assign bus.rsp_err   = rsp_err_r;
endmodule

// File: tb/tb_dl_shift_arb.sv
// Randomized and directed bench for dl_shift_arb (NUM_BITS=32, NUM_REQ=4) against a behavioural model.
// Honours DL_SHIFT_ARB_LSHIFT_EN the same way the design does.
module tb_dl_shift_arb;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    // Reference state: pending response and round-robin pointer.
    logic        mv;
    logic [31:0] md;
    logic [1:0]  mid;
    logic        me;
    int          ptr_m;

    dl_shift_arb_if #(.NUM_BITS(32), .NUM_REQ(4)) bus ();

    dl_shift_arb #(.NUM_BITS(32), .NUM_REQ(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [32:0] ref_op(input logic [1:0] op, input logic [31:0] d, input int sh);
        case (op)
            2'b00:   return {1'b0, d >> sh};
            2'b01:   return {1'b0, 32'($signed(d) >>> sh)};
`ifdef DL_SHIFT_ARB_LSHIFT_EN
            2'b10:   return {1'b0, d << sh};
`endif
            default: return {1'b1, d};
        endcase
    endfunction

    task automatic model_reset();
        mv = 1'b0; md = 32'h0; mid = 2'd0; me = 1'b0; ptr_m = 0;
    endtask

    // Called just after a falling edge with inputs applied; checks ready, then the response after the edge.
    task automatic step(output int got);
        int g;
        logic acc;
        logic [3:0] er;
        logic [32:0] r;
        g = -1;
        for (int k = 0; k < 4; k++) begin
            if (g < 0 && bus.req_valid[(ptr_m + k) % 4]) g = (ptr_m + k) % 4;
        end
        acc = !mv || bus.rsp_ready;
        er = 4'b0000;
        if (g >= 0 && acc) er[g] = 1'b1;
        #1;
        check_val("req_ready", 64'(bus.req_ready), 64'(er));
        @(posedge clk);
        if (g >= 0 && acc) begin
            r = ref_op(bus.req_op[g], bus.req_data[g], int'(bus.req_shamt[g]));
            mv = 1'b1; me = r[32]; md = r[31:0]; mid = 2'(g);
            ptr_m = (g + 1) % 4;
            got = g;
        end else begin
            got = -1;
            if (bus.rsp_ready) mv = 1'b0;
        end
        #1;
        check_val("rsp_valid", 64'(bus.rsp_valid), 64'(mv));
        if (mv) begin
            check_val("rsp_data", 64'(bus.rsp_data), 64'(md));
            check_val("rsp_id", 64'(bus.rsp_id), 64'(mid));
            check_val("rsp_err", 64'(bus.rsp_err), 64'(me));
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh);
        bus.req_valid[i] = v;
        bus.req_op[i]    = op;
        bus.req_data[i]  = d;
        bus.req_shamt[i] = sh;
    endtask

    initial begin
        int got;
        int ids [6];
        n_cmp = 0;
        n_bad = 0;
        model_reset();
        rst_n = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 2'b00, 32'h0, 5'd0);
        #12;
        check_val("rst_valid", 64'(bus.rsp_valid), 64'(1'b0));
        check_val("rst_data", 64'(bus.rsp_data), 64'(32'h0));
        check_val("rst_id", 64'(bus.rsp_id), 64'(2'd0));
        check_val("rst_err", 64'(bus.rsp_err), 64'(1'b0));
        check_val("rst_ready", 64'(bus.req_ready), 64'(4'b0000));
        for (int i = 0; i < 4; i++) bus.req_valid[i] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // SRA of a negative operand.
        @(negedge clk);
        set_req(0, 1'b1, 2'b01, 32'h8000_0000, 5'd4);
        step(got);
        check_val("sra_const", 64'(bus.rsp_data), 64'(32'hF800_0000));
        check_val("sra_id", 64'(bus.rsp_id), 64'(2'd0));

        // SRL, then shamt 0.
        @(negedge clk);
        set_req(0, 1'b0, 2'b00, 32'h0, 5'd0);
        set_req(2, 1'b1, 2'b00, 32'h8000_0000, 5'd4);
        step(got);
        check_val("srl_const", 64'(bus.rsp_data), 64'(32'h0800_0000));
        check_val("srl_id", 64'(bus.rsp_id), 64'(2'd2));
        @(negedge clk);
        set_req(2, 1'b1, 2'b00, 32'hDEAD_BEEF, 5'd0);
        step(got);
        check_val("shamt0", 64'(bus.rsp_data), 64'(32'hDEAD_BEEF));

        // Move the pointer back to 0 through req3.
        @(negedge clk);
        set_req(2, 1'b0, 2'b00, 32'h0, 5'd0);
        set_req(3, 1'b1, 2'b01, 32'h1234_5678, 5'd31);
        step(got);

        // All four valid: back-to-back rotation, then req1 idle.
        ids = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 2'(i), 32'hA5A5_0000 + 32'(i), 5'(i + 3));
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            step(got);
            check_val("rr_seq", 64'(bus.rsp_id), 64'(ids[c]));
        end
        ids = '{2, 3, 0, 2, 3, 0};
        bus.req_valid[1] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            step(got);
            check_val("rr_skip", 64'(bus.rsp_id), 64'(ids[c]));
        end

        // Backpressure for 3 cycles, then drain and accept together.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.rsp_ready = 1'b0;
            step(got);
            check_val("bp_id", 64'(bus.rsp_id), 64'(2'd0));
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        step(got);
        check_val("bp_release", 64'(bus.rsp_id), 64'(2'd2));

        // Left shift and the reserved op.
        @(negedge clk);
        for (int i = 0; i < 4; i++) bus.req_valid[i] = 1'b0;
        set_req(1, 1'b1, 2'b10, 32'h0000_0001, 5'd31);
        step(got);
`ifdef DL_SHIFT_ARB_LSHIFT_EN
        check_val("sll_data", 64'(bus.rsp_data), 64'(32'h8000_0000));
        check_val("sll_err", 64'(bus.rsp_err), 64'(1'b0));
`else
        check_val("sll_data", 64'(bus.rsp_data), 64'(32'h0000_0001));
        check_val("sll_err", 64'(bus.rsp_err), 64'(1'b1));
`endif
        @(negedge clk);
        set_req(1, 1'b1, 2'b11, 32'hCAFE_F00D, 5'd7);
        step(got);
        check_val("op11_err", 64'(bus.rsp_err), 64'(1'b1));
        check_val("op11_data", 64'(bus.rsp_data), 64'(32'hCAFE_F00D));

        // Random traffic with held payloads, occasional drops and random backpressure.
        @(negedge clk);
        for (int i = 0; i < 4; i++) bus.req_valid[i] = 1'b0;
        got = -1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!bus.req_valid[i] || got == i) begin
                    set_req(i, ($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)),
                            $urandom, 5'($urandom_range(0, 31)));
                end else if ($urandom_range(0, 15) == 0) begin
                    bus.req_valid[i] = 1'b0;
                end
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            step(got);
            @(negedge clk);
        end

        // Async reset with a response pending and the pointer at 2.
        for (int i = 0; i < 4; i++) bus.req_valid[i] = 1'b0;
        bus.rsp_ready = 1'b1;
        set_req(1, 1'b1, 2'b00, 32'h0000_00F0, 5'd4);
        step(got);
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        bus.rsp_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_val("arst_valid", 64'(bus.rsp_valid), 64'(1'b0));
        check_val("arst_data", 64'(bus.rsp_data), 64'(32'h0));
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 2'b00, 32'h100 + 32'(i), 5'd1);
        step(got);
        check_val("arst_first_id", 64'(bus.rsp_id), 64'(2'd0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dl_shift_arb.md
Name: dl_shift_arb

Overview:
- Shares one shift datapath (logical/arithmetic right shift, optional left shift) among NUM_REQ requesters.
- Round-robin arbitration with a valid/ready handshake on each requester port.
- One registered response stage, tagged with the requester ID.
- Sits between the ALU issue logic and a single shifter instance, so several pipes can use one barrel shifter.

Parameters:
- NUM_BITS, 32, datapath width; power of 2, >=2.
- NUM_REQ, 4, number of requesters; >=2.
- NUM_SHIFT_BITS, $clog2(NUM_BITS), localparam, shift-amount width.
- ID_BITS, $clog2(NUM_REQ), localparam, requester ID width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_op  in  NUM_REQ x 2  op per requester: 00 SRL, 01 SRA, 10 SLL, 11 reserved.
- req_data  in  NUM_REQ x NUM_BITS  operand.
- req_shamt  in  NUM_REQ x NUM_SHIFT_BITS  shift amount.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  NUM_BITS  shift result.
- rsp_id  out  ID_BITS  index of the requester that issued the response.
- rsp_err  out  1  op was unsupported; rsp_data = operand unchanged.

Behaviour:
- Reset values: rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, RR pointer=0. req_ready is combinational and is 0 while in reset.
- Reset mid-operation: the in-flight response is dropped immediately (async); no replay.
- can_accept = !rsp_valid | rsp_ready.
- Grant: the first i with req_valid[i], searching from the RR pointer upward and wrapping at NUM_REQ-1 -> 0. Grant is combinational.
- req_ready[i] = grant[i] & can_accept. Transfer occurs when req_valid[i] & req_ready[i] at a rising edge.
- Requesters hold valid and payload stable until transferred. Dropping valid before transfer is allowed and never causes a spurious transfer.
- On transfer: pointer <= winner+1 (mod NUM_REQ). Otherwise the pointer holds, including under backpressure.
- Latency: transfer at edge k -> rsp_valid=1 with result from edge k. Throughput is one op per cycle while rsp_ready=1.
- Backpressure: while rsp_valid & !rsp_ready, rsp_data/rsp_id/rsp_err stay stable and all req_ready=0.
- Simultaneous drain and accept in the same cycle is legal: the new result replaces the old one with no bubble.
- rsp_valid falls only when rsp_ready=1 and no new transfer occurs.
- Arithmetic:
  - SRL fills with 0.
  - SRA fills with operand[NUM_BITS-1].
  - shamt=0 returns the operand.
  - Maximum shamt is NUM_BITS-1; there is no modulo beyond the port width.
- SLL is implemented by bit-reversing the operand, applying SRL, then reversing the result.
- Op 11 always: rsp_err=1, rsp_data=operand.
- Empty arbiter (no req_valid): no transfer, pointer holds.

Optional Feature:
- Macro DL_SHIFT_ARB_LSHIFT_EN.
- Defined: op 10 performs SLL as above with rsp_err=0.
- Undefined: the reversal logic is not built; op 10 behaves like op 11 (rsp_err=1, rsp_data=operand).

Test Plan (NUM_BITS=32, NUM_REQ=4):
- Only req0 valid, op SRA, data 0x80000000, shamt 4 -> next cycle rsp_valid=1, rsp_data=0xF8000000, rsp_id=0, rsp_err=0.
- Only req2 valid, op SRL, data 0x80000000, shamt 4 -> rsp_data=0x08000000, rsp_id=2. Also shamt 0 -> data unchanged.
- All four valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1, one response per cycle, no bubbles. Then hold req1 idle -> sequence skips 1.
- With rsp_valid=1, hold rsp_ready=0 for 3 cycles -> rsp outputs stable and req_ready all 0. Raise rsp_ready -> old response consumed and next request accepted in the same cycle.
- Op SLL, data 0x00000001, shamt 31:
  - Macro defined -> 0x80000000, rsp_err=0.
  - Macro undefined -> rsp_data=0x00000001, rsp_err=1.
  - Op 11 -> rsp_err=1 in both builds.
- Assert rst_n=0 asynchronously while rsp_valid=1 and pointer=2 -> rsp_valid=0 before the next edge. After release with all valid, the first grant goes to req0.
